pin_driver: RTL and testbench
=============================

// Module: pin_driver
// PURPOSE
//  Output-side companion of the GPIO input filter: drives a WIDTH-bit cartridge/GPIO data
//  bus through tri-state pads with controlled setup, hold and turnaround timing. The core
//  requests the bus with a level handshake; the block sequences data/output-enable so the
//  pads never glitch and never collide with the external driver. Sits between bus-cycle
//  logic and the top-level inout assignments (pad = oe ? dout : 'z).
// PARAMETERS
//  WIDTH      8  data bus width in bits
//  SETUP_CYC  1  ena ticks data is held on dout with oe low before oe asserts (0 = skip)
//  HOLD_CYC   2  ena ticks oe stays high, data frozen, after drv_req drops (0 = skip)
//  TURN_CYC   1  ena ticks after oe release during which a new request is not accepted
// PORTS
//  clk       in   1      system clock; the block's only clock
//  reset     in   1      asynchronous, active-high reset
//  ena       in   1      time-base strobe; all sequencing advances only when ena=1
//  drv_req   in   1      level: 1 = core wants to drive the bus
//  din       in   WIDTH  data to drive
//  dout      out  WIDTH  pad output data
//  oe        out  1      pad output enable, 1 = driving
//  busy      out  1      1 whenever state != IDLE
//  done      out  1      one-clk pulse when the bus is released (oe 1->0)
// BEHAVIOUR
//  Reset: state IDLE, oe=0, dout='1 (bus idles high), busy=0, done=0, counter=0.
//   oe clears asynchronously on reset assertion, including mid-DRIVE/HOLD.
//  All outputs registered. Inputs (drv_req, din) sampled only on clk edges with ena=1;
//   with ena=0 state, counter, dout and oe hold; done is 0.
//  States: IDLE, SETUP, DRIVE, HOLD, TURN. Counter counts ena ticks from 0 in each timed state.
//  IDLE:  drv_req=1 -> dout<=din; SETUP if SETUP_CYC>0 else DRIVE with oe<=1 same edge.
//  SETUP: oe=0, dout frozen. After SETUP_CYC ticks -> DRIVE, oe<=1, dout<=din.
//         drv_req=0 sampled in SETUP -> abort to IDLE (oe never rose; no TURN, no done).
//  DRIVE: oe=1; every ena tick dout<=din. drv_req=0 -> HOLD (HOLD_CYC>0) with dout frozen
//         at last value, else release directly (oe<=0, done pulse, -> TURN/IDLE).
//  HOLD:  oe=1, dout frozen, drv_req ignored. After HOLD_CYC ticks: oe<=0, done=1 for one
//         clk, -> TURN (TURN_CYC>0) else IDLE. dout returns to '1 on release.
//  TURN:  oe=0, drv_req ignored; after TURN_CYC ticks -> IDLE. A request held through TURN
//         is accepted on the first ena tick in IDLE.
//  Latency: drv_req rise -> oe=1 is exactly SETUP_CYC+1 ena ticks; drv_req fall -> oe=0 is
//   exactly HOLD_CYC+1 ena ticks. Minimum oe-low gap between drives: TURN_CYC+1 ticks.
//  Counter width $clog2(max(SETUP_CYC,HOLD_CYC,TURN_CYC)+1), min 1 bit; compare ==CYC-1,
//   never wraps. Invalid states decode to IDLE with oe=0.
// STRUCTURE
//  pin_pkg: state enum typedef pin_drv_state_t, function cnt_width(a,b,c), DOUT_IDLE fill
//   constant. Shared with pinfilter-adjacent bus logic.
//  Sub-module tick_timer: load/clear, ena-gated up-counter with terminal-count flag at
//   parameterised limit; pin_driver instantiates one, reloaded on each state entry.
// TESTING
//  1 Defaults, ena every clk, din=8'hA5, drv_req 1 for 5 ticks -> oe high 2 ticks after req,
//    dout=8'hA5, oe low 3 ticks after req fall, single done pulse, busy low after TURN.
//  2 ena every 4th clk -> same tick counts; oe edges only on ena clocks; no change when ena=0.
//  3 drv_req pulse 1 tick, SETUP_CYC=2 -> abort in SETUP, oe never 1, done never 1.
//  4 din changes 8'h11->8'h22 in DRIVE then req drops -> dout 8'h22 held through HOLD;
//    change din to 8'h33 in HOLD -> dout stays 8'h22.
//  5 drv_req held high across release -> oe low exactly TURN_CYC+1 ticks, then re-drive.
//  6 reset asserted mid-HOLD -> oe=0 asynchronously same cycle, dout=8'hFF, state IDLE.

Source files
------------

// File: rtl/pin_pkg.sv
// Shared types and helpers for the GPIO pad driver and its neighbouring bus logic.
package pin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_DRIVE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_TURN  = 3'd4
    } pin_drv_state_t;

    // The bus idles high; replicate this bit to any data width.
    localparam logic DOUT_IDLE = 1'b1;

    // Width of a counter able to reach the largest of three cycle counts, at least 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if ($clog2(m + 1) < 1) return 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Ena-gated up-counter with a terminal-count flag at a run-time selectable limit.
module tick_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ena,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count_reg;

    // Saturates at limit-1 so the count never wraps while a state lingers.
    assign tc = (count_reg == (limit - W'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (ena && !tc) begin
            count_reg <= count_reg + W'(1);
        end
    end

endmodule

// File: rtl/pin_driver.sv
// Tri-state pad sequencer: setup, drive, hold and turnaround phases around a level request.
module pin_driver
    import pin_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 2,
    parameter int TURN_CYC  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             drv_req,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             oe,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(SETUP_CYC, HOLD_CYC, TURN_CYC);
    localparam logic [WIDTH-1:0] DOUT_REST = {WIDTH{DOUT_IDLE}};
    localparam logic [CW-1:0] SETUP_LIM = CW'(SETUP_CYC);
    localparam logic [CW-1:0] HOLD_LIM  = CW'(HOLD_CYC);
    localparam logic [CW-1:0] TURN_LIM  = CW'(TURN_CYC);

    pin_drv_state_t   state_reg, state_next;
    logic             oe_reg, oe_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             done_reg, done_next;
    logic             busy_reg;
    logic             do_release;
    logic [CW-1:0]    timer_limit;
    logic             timer_clear;
    logic             timer_tc;

    always_comb begin
        timer_limit = CW'(1);
        case (state_reg)
            ST_SETUP: timer_limit = SETUP_LIM;
            ST_HOLD:  timer_limit = HOLD_LIM;
            ST_TURN:  timer_limit = TURN_LIM;
            default:  timer_limit = CW'(1);
        endcase
    end

    // Restart the count on every state entry so each timed phase starts from zero.
    assign timer_clear = (state_next != state_reg);

    tick_timer #(
        .W(CW)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .ena   (ena),
        .clear (timer_clear),
        .limit (timer_limit),
        .tc    (timer_tc)
    );

    always_comb begin
        state_next = state_reg;
        oe_next    = oe_reg;
        dout_next  = dout_reg;
        done_next  = 1'b0;
        do_release = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                oe_next = 1'b0;
                if (ena && drv_req) begin
                    dout_next = din;
                    if (SETUP_CYC > 0) begin
                        state_next = ST_SETUP;
                    end else begin
                        state_next = ST_DRIVE;
                        oe_next    = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (ena) begin
                    if (!drv_req) begin
                        // Abort before oe ever rose: no turnaround and no done pulse.
                        state_next = ST_IDLE;
                        dout_next  = DOUT_REST;
                    end else if (timer_tc) begin
                        state_next = ST_DRIVE;
                        oe_next    = 1'b1;
                        dout_next  = din;
                    end
                end
            end
            ST_DRIVE: begin
                if (ena) begin
                    if (drv_req) begin
                        dout_next = din;
                    end else if (HOLD_CYC > 0) begin
                        state_next = ST_HOLD;
                    end else begin
                        do_release = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (ena && timer_tc) begin
                    do_release = 1'b1;
                end
            end
            ST_TURN: begin
                if (ena && timer_tc) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                oe_next    = 1'b0;
                dout_next  = DOUT_REST;
            end
        endcase
        if (do_release) begin
            oe_next    = 1'b0;
            done_next  = 1'b1;
            dout_next  = DOUT_REST;
            state_next = (TURN_CYC > 0) ? ST_TURN : ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            oe_reg    <= 1'b0;
            dout_reg  <= DOUT_REST;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            oe_reg    <= oe_next;
            dout_reg  <= dout_next;
            done_reg  <= done_next;
            busy_reg  <= (state_next != ST_IDLE);
        end
    end

    assign dout = dout_reg;
    assign oe   = oe_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_pin_driver.sv
// Directed bench for pin_driver: default, long-setup and zero-setup/zero-hold instances.
module tb_pin_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       drv_req;
    logic [7:0] din;

    logic [7:0] dout_def, dout_s2, dout_s0;
    logic       oe_def, oe_s2, oe_s0;
    logic       busy_def, busy_s2, busy_s0;
    logic       done_def, done_s2, done_s0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       req;
        logic [7:0] din;
        logic       oe;
        logic [7:0] dout;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[17];

    always #5 clk = ~clk;

    pin_driver u_def (
        .clk(clk), .reset(reset), .ena(ena), .drv_req(drv_req), .din(din),
        .dout(dout_def), .oe(oe_def), .busy(busy_def), .done(done_def)
    );

    pin_driver #(.SETUP_CYC(2)) u_s2 (
        .clk(clk), .reset(reset), .ena(ena), .drv_req(drv_req), .din(din),
        .dout(dout_s2), .oe(oe_s2), .busy(busy_s2), .done(done_s2)
    );

    pin_driver #(.SETUP_CYC(0), .HOLD_CYC(0)) u_s0 (
        .clk(clk), .reset(reset), .ena(ena), .drv_req(drv_req), .din(din),
        .dout(dout_s0), .oe(oe_s0), .busy(busy_s0), .done(done_s0)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        ena = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drv_req = 1'b0;
        repeat (n) tick();
    endtask

    // One row = one ena tick, spread over div clocks; outputs must not move between ticks.
    task automatic apply_row(input int i, input int div, input logic prev_oe, input logic [7:0] prev_dout);
        drv_req = vecs[i].req;
        din     = vecs[i].din;
        for (int k = 0; k < div; k++) begin
            ena = (k == div - 1);
            @(posedge clk);
            #1;
            if (k != div - 1) begin
                chk($sformatf("row%0d_div%0d_hold_oe", i, div), oe_def, prev_oe);
                chk($sformatf("row%0d_div%0d_hold_dout", i, div), dout_def, prev_dout);
                chk($sformatf("row%0d_div%0d_hold_done", i, div), done_def, 1'b0);
            end
        end
        chk($sformatf("row%0d_div%0d_oe", i, div), oe_def, vecs[i].oe);
        chk($sformatf("row%0d_div%0d_dout", i, div), dout_def, vecs[i].dout);
        chk($sformatf("row%0d_div%0d_busy", i, div), busy_def, vecs[i].busy);
        chk($sformatf("row%0d_div%0d_done", i, div), done_def, vecs[i].done);
        $display("[TB] vec %0d div=%0d req=%0b din=%02h -> oe=%0b dout=%02h busy=%0b done=%0b",
                 i, div, vecs[i].req, vecs[i].din, oe_def, dout_def, busy_def, done_def);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] req_pat;
        logic [7:0] def_oe_pat;
        logic [7:0] def_done_pat;
        logic [7:0] s0_oe_pat;
        logic [7:0] s0_done_pat;

        //              req   din    oe    dout   busy  done
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'hA5, 1'b0, 8'hFF, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 8'hA5, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'hA5, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h11, 1'b0, 8'h11, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'h22, 1'b1, 8'h22, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 8'h22, 1'b1, 8'h22, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 8'h33, 1'b1, 8'h22, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 8'h33, 1'b0, 8'hFF, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 8'h33, 1'b0, 8'hFF, 1'b0, 1'b0};

        reset   = 1'b0;
        ena     = 1'b0;
        drv_req = 1'b0;
        din     = 8'h00;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_oe", oe_def, 1'b0);
        chk("reset_dout", dout_def, 8'hFF);
        chk("reset_busy", busy_def, 1'b0);
        chk("reset_done", done_def, 1'b0);
        chk("reset_s2_dout", dout_s2, 8'hFF);
        chk("reset_s0_oe", oe_s0, 1'b0);
        reset = 1'b0;
        idle(2);

        // Basic drive sequence and data tracking / freezing, ena every clock.
        for (int i = 0; i < 17; i++) apply_row(i, 1, 1'b0, 8'h00);
        idle(3);

        // Same sequence with ena every 4th clock.
        for (int i = 0; i < 10; i++) begin
            if (i == 0) apply_row(i, 4, 1'b0, 8'hFF);
            else        apply_row(i, 4, vecs[i-1].oe, vecs[i-1].dout);
        end
        idle(6);

        // Single-tick request: aborts in SETUP on the long-setup instance.
        din     = 8'h3C;
        drv_req = 1'b1;
        tick();
        chk("abort_s2_oe_t0", oe_s2, 1'b0);
        chk("abort_s2_busy_t0", busy_s2, 1'b1);
        chk("abort_s2_dout_t0", dout_s2, 8'h3C);
        chk("s0_oe_t0", oe_s0, 1'b1);
        chk("s0_dout_t0", dout_s0, 8'h3C);
        drv_req = 1'b0;
        tick();
        chk("abort_s2_oe_t1", oe_s2, 1'b0);
        chk("abort_s2_busy_t1", busy_s2, 1'b0);
        chk("abort_s2_dout_t1", dout_s2, 8'hFF);
        chk("abort_s2_done_t1", done_s2, 1'b0);
        chk("abort_def_done_t1", done_def, 1'b0);
        chk("s0_done_t1", done_s0, 1'b1);
        chk("s0_oe_t1", oe_s0, 1'b0);
        chk("s0_busy_t1", busy_s0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("abort_s2_oe_after%0d", k), oe_s2, 1'b0);
            chk($sformatf("abort_s2_done_after%0d", k), done_s2, 1'b0);
            chk($sformatf("s0_done_after%0d", k), done_s0, 1'b0);
        end
        idle(4);

        // Request held across release: turnaround gap before re-drive.
        req_pat      = 8'b11111011;
        def_oe_pat   = 8'b10001110;
        def_done_pat = 8'b00010000;
        s0_oe_pat    = 8'b11110011;
        s0_done_pat  = 8'b00000100;
        din = 8'h77;
        for (int t = 0; t < 8; t++) begin
            drv_req = req_pat[t];
            tick();
            chk($sformatf("turn_def_oe_t%0d", t), oe_def, def_oe_pat[t]);
            chk($sformatf("turn_def_done_t%0d", t), done_def, def_done_pat[t]);
            chk($sformatf("turn_s0_oe_t%0d", t), oe_s0, s0_oe_pat[t]);
            chk($sformatf("turn_s0_done_t%0d", t), done_s0, s0_done_pat[t]);
            $display("[TB] turn t%0d req=%0b def_oe=%0b s0_oe=%0b", t, drv_req, oe_def, oe_s0);
        end
        idle(8);

        // Asynchronous reset in the middle of HOLD.
        din     = 8'h5A;
        drv_req = 1'b1;
        tick();
        tick();
        drv_req = 1'b0;
        tick();
        chk("areset_pre_oe", oe_def, 1'b1);
        chk("areset_pre_dout", dout_def, 8'h5A);
        #2 reset = 1'b1;
        #1;
        chk("areset_oe", oe_def, 1'b0);
        chk("areset_dout", dout_def, 8'hFF);
        chk("areset_busy", busy_def, 1'b0);
        chk("areset_done", done_def, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        chk("areset_after_oe", oe_def, 1'b0);
        chk("areset_after_busy", busy_def, 1'b0);
        chk("areset_after_dout", dout_def, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
